// File: rtl/cbus_rx_sync_ctrl.sv
// Cbus receive link-sync controller: HUNT/ACQ/SYNC on K28.5 commas, saturating in-sync error counter.
// Optional hunt timeout and PCS reset request are enabled by defining CBUS_RX_SYNC_AUTORST_EN.
module cbus_rx_sync_ctrl #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         ACQ_CNT  = 3,
    parameter int         GOOD_CNT = 4,
    parameter int         MAX_ERR  = 4,
    parameter int         TIMEOUT  = 4095,
    parameter int         RST_LEN  = 8,
    parameter int         ERR_W    = 16
) (
    input  logic             pcs_rxclk,
    input  logic             pcs_rxrst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_charisk,
    input  logic             rx_disperr,
    input  logic             rx_notintable,
    input  logic             rx_valid,
    input  logic             err_clr,
    output logic             rx_sync,
    output logic             rx_rst_req,
    output logic [1:0]       sync_state,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        ACQ    = 2'b01,
        SYNC   = 2'b10,
        RESYNC = 2'b11
    } state_t;

    localparam int AW = $clog2(ACQ_CNT + 1);
    localparam int LW = $clog2(MAX_ERR + 1);
    localparam int GW = $clog2(GOOD_CNT + 1);
    localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_CNT - 1);
    localparam logic [LW-1:0] ERR_LAST  = LW'(MAX_ERR - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_CNT - 1);

    state_t             state_reg;
    logic [AW-1:0]      acq_cnt_reg;
    logic [LW-1:0]      err_level_reg;
    logic [GW-1:0]      good_run_reg;
    logic               rx_sync_reg;
    logic [ERR_W-1:0]   err_cnt_reg;

    logic sym_bad;
    logic sym_err;
    logic sym_comma;
    logic sym_good;

    assign sym_bad   = rx_disperr | rx_notintable;
    assign sym_err   = rx_valid & sym_bad;
    assign sym_comma = rx_valid & ~sym_bad & rx_charisk & (rx_data == COMMA);
    assign sym_good  = rx_valid & ~sym_bad;

    assign sync_state = state_reg;
    assign rx_sync    = rx_sync_reg;
    assign err_cnt    = err_cnt_reg;

`ifdef CBUS_RX_SYNC_AUTORST_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RST_LEN + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_LEN - 1);

    logic [TW-1:0] hunt_tmr_reg;
    logic [RW-1:0] rst_cnt_reg;
    logic          rx_rst_req_reg;

    assign rx_rst_req = rx_rst_req_reg;
`else
    assign rx_rst_req = 1'b0;
`endif

    always_ff @(posedge pcs_rxclk or negedge pcs_rxrst_n) begin
        if (!pcs_rxrst_n) begin
            state_reg      <= HUNT;
            acq_cnt_reg    <= '0;
            err_level_reg  <= '0;
            good_run_reg   <= '0;
            rx_sync_reg    <= 1'b0;
            err_cnt_reg    <= '0;
`ifdef CBUS_RX_SYNC_AUTORST_EN
            hunt_tmr_reg   <= '0;
            rst_cnt_reg    <= '0;
            rx_rst_req_reg <= 1'b0;
`endif
        end else begin
            // Clear has priority over an increment in the same cycle.
            if (err_clr) begin
                err_cnt_reg <= '0;
            end else if (state_reg == SYNC && sym_err && err_cnt_reg != '1) begin
                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
            end

            case (state_reg)
                HUNT: begin
                    if (sym_comma) begin
`ifdef CBUS_RX_SYNC_AUTORST_EN
                        hunt_tmr_reg <= '0;
`endif
                        if (ACQ_CNT == 1) begin
                            state_reg     <= SYNC;
                            rx_sync_reg   <= 1'b1;
                            err_level_reg <= '0;
                            good_run_reg  <= '0;
                            acq_cnt_reg   <= '0;
                        end else begin
                            state_reg   <= ACQ;
                            acq_cnt_reg <= AW'(1);
                        end
                    end
`ifdef CBUS_RX_SYNC_AUTORST_EN
                    else if (hunt_tmr_reg == TMR_LAST) begin
                        state_reg      <= RESYNC;
                        hunt_tmr_reg   <= '0;
                        rst_cnt_reg    <= '0;
                        rx_rst_req_reg <= 1'b1;
                    end else begin
                        hunt_tmr_reg <= hunt_tmr_reg + TW'(1);
                    end
`endif
                end

                ACQ: begin
                    if (sym_err) begin
                        state_reg   <= HUNT;
                        acq_cnt_reg <= '0;
                    end else if (sym_comma) begin
                        if (acq_cnt_reg == ACQ_LAST) begin
                            state_reg     <= SYNC;
                            rx_sync_reg   <= 1'b1;
                            err_level_reg <= '0;
                            good_run_reg  <= '0;
                            acq_cnt_reg   <= '0;
                        end else begin
                            acq_cnt_reg <= acq_cnt_reg + AW'(1);
                        end
                    end
                end

                SYNC: begin
                    if (sym_err) begin
                        good_run_reg <= '0;
                        if (err_level_reg == ERR_LAST) begin
                            state_reg     <= HUNT;
                            rx_sync_reg   <= 1'b0;
                            err_level_reg <= '0;
                        end else begin
                            err_level_reg <= err_level_reg + LW'(1);
                        end
                    end else if (sym_good) begin
                        // A full run of good symbols forgives one earlier error.
                        if (good_run_reg == GOOD_LAST) begin
                            good_run_reg <= '0;
                            if (err_level_reg != '0) begin
                                err_level_reg <= err_level_reg - LW'(1);
                            end
                        end else begin
                            good_run_reg <= good_run_reg + GW'(1);
                        end
                    end
                end

`ifdef CBUS_RX_SYNC_AUTORST_EN
                RESYNC: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        state_reg      <= HUNT;
                        rst_cnt_reg    <= '0;
                        rx_rst_req_reg <= 1'b0;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + RW'(1);
                    end
                end
`endif

                default: state_reg <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_rx_sync_ctrl.sv
// Directed table-driven bench for cbus_rx_sync_ctrl, plus sequences for timeout/RESYNC and counter saturation.
module tb_cbus_rx_sync_ctrl;

`ifdef CBUS_RX_SYNC_AUTORST_EN
    localparam bit AUTORST = 1'b1;
`else
    localparam bit AUTORST = 1'b0;
`endif

    localparam logic [1:0] ST_HUNT = 2'b00;
    localparam logic [1:0] ST_ACQ  = 2'b01;
    localparam logic [1:0] ST_SYNC = 2'b10;
    localparam logic [1:0] ST_RSYN = 2'b11;

    // symbol kinds used by the stimulus table
    localparam int S_C  = 0;  // K28.5 comma
    localparam int S_G  = 1;  // good data byte
    localparam int S_E  = 2;  // disparity error
    localparam int S_N  = 3;  // not-in-table
    localparam int S_I  = 4;  // rx_valid = 0
    localparam int S_KN = 5;  // K char that is not a comma
    localparam int S_BN = 6;  // 0xBC as data (not K)
    localparam int S_CE = 7;  // comma with disparity error

    typedef struct {
        int          sym;
        logic        clr;
        logic [1:0]  st;
        logic        sy;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tmo_rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_charisk = 1'b0;
    logic       rx_disperr = 1'b0;
    logic       rx_notintable = 1'b0;
    logic       rx_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] zero8 = 8'h00;
    logic       zero1 = 1'b0;

    logic        d_sync, d_req;
    logic [1:0]  d_st;
    logic [15:0] d_err;
    logic        s_sync, s_req;
    logic [1:0]  s_st;
    logic [3:0]  s_err;
    logic        t_sync, t_req;
    logic [1:0]  t_st;
    logic [15:0] t_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cbus_rx_sync_ctrl u_dut (
        .pcs_rxclk(clk), .pcs_rxrst_n(rst_n), .rx_data(rx_data), .rx_charisk(rx_charisk),
        .rx_disperr(rx_disperr), .rx_notintable(rx_notintable), .rx_valid(rx_valid),
        .err_clr(err_clr), .rx_sync(d_sync), .rx_rst_req(d_req), .sync_state(d_st), .err_cnt(d_err)
    );

    cbus_rx_sync_ctrl #(.ERR_W(4), .MAX_ERR(32)) u_sat (
        .pcs_rxclk(clk), .pcs_rxrst_n(rst_n), .rx_data(rx_data), .rx_charisk(rx_charisk),
        .rx_disperr(rx_disperr), .rx_notintable(rx_notintable), .rx_valid(rx_valid),
        .err_clr(err_clr), .rx_sync(s_sync), .rx_rst_req(s_req), .sync_state(s_st), .err_cnt(s_err)
    );

    cbus_rx_sync_ctrl #(.TIMEOUT(16), .RST_LEN(8)) u_tmo (
        .pcs_rxclk(clk), .pcs_rxrst_n(tmo_rst_n), .rx_data(zero8), .rx_charisk(zero1),
        .rx_disperr(zero1), .rx_notintable(zero1), .rx_valid(zero1),
        .err_clr(zero1), .rx_sync(t_sync), .rx_rst_req(t_req), .sync_state(t_st), .err_cnt(t_err)
    );

    function automatic void add(input int sym, input logic clr, input logic [1:0] st,
                                input logic sy, input int ec);
        vec_t v;
        v.sym = sym; v.clr = clr; v.st = st; v.sy = sy; v.ec = 16'(ec);
        vecs.push_back(v);
    endfunction

    task automatic drive(input int sym, input logic clr);
        rx_valid = 1'b1; rx_charisk = 1'b0; rx_disperr = 1'b0; rx_notintable = 1'b0;
        rx_data = 8'h55; err_clr = clr;
        case (sym)
            S_C:  begin rx_data = 8'hBC; rx_charisk = 1'b1; end
            S_E:  rx_disperr = 1'b1;
            S_N:  rx_notintable = 1'b1;
            S_I:  begin rx_valid = 1'b0; rx_data = 8'hBC; rx_charisk = 1'b1; end
            S_KN: begin rx_data = 8'h1C; rx_charisk = 1'b1; end
            S_BN: rx_data = 8'hBC;
            S_CE: begin rx_data = 8'hBC; rx_charisk = 1'b1; rx_disperr = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        // T1: acquire
        add(S_C, 0, ST_ACQ, 0, 0); add(S_C, 0, ST_ACQ, 0, 0); add(S_C, 0, ST_SYNC, 1, 0);
        // T2: four errors, three good between, drop on the 4th
        add(S_E, 0, ST_SYNC, 1, 1);
        repeat (3) add(S_G, 0, ST_SYNC, 1, 1);
        add(S_E, 0, ST_SYNC, 1, 2);
        repeat (3) add(S_G, 0, ST_SYNC, 1, 2);
        add(S_E, 0, ST_SYNC, 1, 3);
        repeat (3) add(S_G, 0, ST_SYNC, 1, 3);
        add(S_E, 0, ST_HUNT, 0, 4);
        // HUNT ignores non-commas; ACQ tolerates idle and non-comma K
        add(S_BN, 0, ST_HUNT, 0, 4); add(S_E, 0, ST_HUNT, 0, 4); add(S_I, 0, ST_HUNT, 0, 4);
        add(S_C, 0, ST_ACQ, 0, 4); add(S_KN, 0, ST_ACQ, 0, 4); add(S_C, 0, ST_ACQ, 0, 4);
        add(S_C, 0, ST_SYNC, 1, 4);
        add(S_I, 1, ST_SYNC, 1, 0);
        // T3: err then four good, ten times
        for (int r = 0; r < 10; r++) begin
            add(S_E, 0, ST_SYNC, 1, r + 1);
            repeat (4) add(S_G, 0, ST_SYNC, 1, r + 1);
        end
        repeat (3) add(S_I, 0, ST_SYNC, 1, 10);
        // four good symbols undo exactly one error level
        add(S_E, 0, ST_SYNC, 1, 11); add(S_E, 0, ST_SYNC, 1, 12); add(S_E, 0, ST_SYNC, 1, 13);
        repeat (4) add(S_G, 0, ST_SYNC, 1, 13);
        add(S_E, 0, ST_SYNC, 1, 14); add(S_E, 0, ST_HUNT, 0, 15);
        add(S_E, 0, ST_HUNT, 0, 15);
        // T4: error in ACQ returns to HUNT
        add(S_C, 0, ST_ACQ, 0, 15); add(S_G, 0, ST_ACQ, 0, 15); add(S_I, 0, ST_ACQ, 0, 15);
        add(S_C, 0, ST_ACQ, 0, 15); add(S_N, 0, ST_HUNT, 0, 15);
        add(S_C, 0, ST_ACQ, 0, 15); add(S_CE, 0, ST_HUNT, 0, 15);
        add(S_C, 0, ST_ACQ, 0, 15); add(S_C, 0, ST_ACQ, 0, 15); add(S_C, 0, ST_SYNC, 1, 15);
        // clear beats a simultaneous error; error level still advances
        add(S_E, 1, ST_SYNC, 1, 0); add(S_E, 0, ST_SYNC, 1, 1);
        add(S_E, 0, ST_SYNC, 1, 2); add(S_E, 0, ST_HUNT, 0, 3);

        drive(S_I, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", {26'd0, d_st, d_sync, d_req, 2'b00}, 32'd0);
        chk("reset_err", {16'd0, d_err}, 32'd0);
        rst_n = 1'b1;
        chk("reset_release", {10'd0, d_st, d_sync, d_req, d_err}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sym, vecs[i].clr);
            @(posedge clk);
            #1;
            $display("vec %0d sym=%0d clr=%0b st=%0d sync=%0b err=%0d", i, vecs[i].sym,
                     vecs[i].clr, d_st, d_sync, d_err);
            chk($sformatf("vec%0d", i), {10'd0, d_st, d_sync, d_req, d_err},
                {10'd0, vecs[i].st, vecs[i].sy, 1'b0, vecs[i].ec});
        end

        // T5: hunt timeout and reset-request pulse train on an idle link
        drive(S_I, 0);
        tmo_rst_n = 1'b1;
        for (int n = 1; n <= 66; n++) begin
            logic exp_req;
            @(posedge clk);
            #1;
            exp_req = AUTORST && (n >= 16) && (((n - 16) % 24) < 8);
            $display("tmo cycle %0d req=%0b st=%0d", n, t_req, t_st);
            chk($sformatf("tmo_req%0d", n), {30'd0, t_req, t_st == ST_RSYN},
                {30'd0, exp_req, exp_req});
        end
        #2 tmo_rst_n = 1'b0;
        #1;
        chk("tmo_async_rst", {29'd0, t_req, t_st}, 32'd0);

        // T6: saturation with a narrow counter, then clear against an error
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(S_C, 0);
            @(posedge clk);
            #1;
            chk($sformatf("sat_acq%0d", i), {30'd0, s_st}, {30'd0, (i == 2) ? ST_SYNC : ST_ACQ});
        end
        for (int i = 1; i <= 20; i++) begin
            drive(S_E, 0);
            @(posedge clk);
            #1;
            $display("sat err %0d cnt=%0d sync=%0b", i, s_err, s_sync);
            chk($sformatf("sat_cnt%0d", i), {27'd0, s_sync, s_err},
                {27'd0, 1'b1, (i > 15) ? 4'd15 : 4'(i)});
        end
        drive(S_E, 1);
        @(posedge clk);
        #1;
        chk("sat_clr_err", {27'd0, s_sync, s_err}, {27'd0, 1'b1, 4'd0});
        drive(S_E, 0);
        @(posedge clk);
        #1;
        chk("sat_after_clr", {27'd0, s_sync, s_err}, {27'd0, 1'b1, 4'd1});
        chk("sat_no_req", {31'd0, s_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
